div_reconstruct: RTL and testbench

Sequential shift-add reconstructor, the inverse of the team's restoring array divider. Takes a quotient, divisor and remainder, and rebuilds the dividend as q*y + r. Used as the multiply side of the divide datapath and as an in-system self-check of divider results. One shift-add iteration per clock, with valid/ready handshakes on both input and output.

---
 rtl/div_reconstruct_pkg.sv | 17 +
 rtl/div_reconstruct_shift_add_step.sv | 20 ++
 rtl/div_reconstruct.sv | 126 ++++++++++++
 tb/tb_div_reconstruct.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/div_reconstruct_pkg.sv
// Shared types and helpers for the q*y + r dividend reconstructor.
package div_reconstruct_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_reconstruct_shift_add_step.sv
// One combinational shift-add iteration: conditional add of the multiplicand,
// then advance multiplicand left and multiplier right by one bit.
module div_reconstruct_shift_add_step
    import div_reconstruct_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0]   o_mplier
);

    assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    assign o_mcand  = i_mcand << 1;
    assign o_mplier = i_mplier >> 1;

endmodule

// File: rtl/div_reconstruct.sv
// Sequential dividend reconstructor: x = q*y + r, one shift-add per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for operands; accept loads acc=r, mcand=y, mplier=q
// ST_RUN  | WIDTH shift-add iterations, one per clock
// ST_DONE | result presented on x with out_valid until out_ready
module div_reconstruct
    import div_reconstruct_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] x,
    output logic               div_zero,
    output logic               rem_err
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam int              AW   = 2 * WIDTH;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_acc;
    logic [AW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CW-1:0]     r_cnt;
    logic              r_div_zero;
    logic              r_rem_err;
    logic [AW-1:0]     w_acc_nxt;
    logic [AW-1:0]     w_mcand_nxt;
    logic [WIDTH-1:0]  w_mplier_nxt;
    logic              w_accept;
    logic              w_last;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == LAST);

    div_reconstruct_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_nxt),
        .o_mcand  (w_mcand_nxt),
        .o_mplier (w_mplier_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; both handshakes depend on state only.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, iterate while running, otherwise hold
    // so x and the flags keep their last values after the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_rem_err  <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= {{WIDTH{1'b0}}, r};
            r_mcand    <= {{WIDTH{1'b0}}, y};
            r_mplier   <= q;
            r_cnt      <= '0;
            r_div_zero <= (y == '0);
            r_rem_err  <= (r >= y);
        end else if (r_state == ST_RUN) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign x        = r_acc;
    assign div_zero = r_div_zero;
    assign rem_err  = r_rem_err;

endmodule

// File: tb/tb_div_reconstruct.sv
// Bench for div_reconstruct: directed cases plus an exhaustive operand sweep
// with random output stalls, checked against plain q*y + r arithmetic.
module tb_div_reconstruct;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] q;
    logic [3:0] y;
    logic [3:0] r;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] x;
    logic       div_zero;
    logic       rem_err;

    int errs   = 0;
    int checks = 0;

    div_reconstruct #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .y         (y),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .div_zero  (div_zero),
        .rem_err   (rem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full transaction: accept, latency, result, optional stall, handshake.
    task automatic do_op(input logic [3:0] qq, input logic [3:0] yy, input logic [3:0] rr,
                         input int stall, input bit pulse);
        logic [7:0] exp_x;
        logic       exp_dz;
        logic       exp_re;
        int         n;
        exp_x  = 8'(int'(qq) * int'(yy) + int'(rr));
        exp_dz = (yy == 4'd0);
        exp_re = (int'(rr) >= int'(yy));

        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);

        q = qq; y = yy; r = rr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        q = 4'($urandom); y = 4'($urandom); r = 4'($urandom);

        n = 0;
        while (!out_valid && n < 50) begin
            chk("run_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        chk("x", 32'(x), 32'(exp_x));
        chk("div_zero", 32'(div_zero), 32'(exp_dz));
        chk("rem_err", 32'(rem_err), 32'(exp_re));

        for (int s = 0; s < stall; s++) begin
            if (pulse) begin
                in_valid = 1'b1;
                q = 4'($urandom); y = 4'($urandom); r = 4'($urandom);
            end
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_x", 32'(x), 32'(exp_x));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_x", 32'(x), 32'(exp_x));
        chk("post_dz", 32'(div_zero), 32'(exp_dz));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q = 4'd0; y = 4'd0; r = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("rst_re", 32'(rem_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(4'hE, 4'hB, 4'h3, 0, 1'b0);
        do_op(4'hF, 4'hF, 4'hF, 0, 1'b0);
        do_op(4'hF, 4'h0, 4'h5, 0, 1'b0);
        do_op(4'h7, 4'h3, 4'h2, 3, 1'b1);

        // Reset during the second RUN cycle.
        q = 4'h9; y = 4'h3; r = 4'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrun_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrun_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_x", 32'(x), 32'd0);
        chk("midrun_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_re", 32'(rem_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'h1, 4'h1, 4'h0, 0, 1'b0);

        for (int i = 0; i < 4096; i++) begin
            logic [11:0] v;
            v = 12'(i);
            do_op(v[11:8], v[7:4], v[3:0], int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
